// File: rtl/dpll_pkg.sv
// Clause encoding shared by the DPLL datapath: a clause is a CLAUSE_W-bit literal-alive mask,
// where a set bit means that literal is not yet falsified.
package dpll_pkg;

  localparam int CLAUSE_W     = 3;
  localparam int MAX_SLOTS    = 64;
  localparam int CLAUSE_TBL_W = CLAUSE_W * MAX_SLOTS;

  // Callers zero-extend their packed table to CLAUSE_TBL_W so one helper serves every table size.
  function automatic logic [CLAUSE_W-1:0] clause_slice(input logic [CLAUSE_TBL_W-1:0] tbl,
                                                       input int unsigned idx);
    return CLAUSE_W'(tbl >> (CLAUSE_W * idx));
  endfunction

  function automatic logic clause_dead(input logic [CLAUSE_W-1:0] lits);
    return ~|lits;
  endfunction

endpackage

// File: rtl/sat_prio_enc.sv
// Lowest-index priority encoder with a found flag. It is purely combinational and has no
// handshake; index 0 has the highest priority and idx is 0 when nothing is requested.
module sat_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the last hit written is the lowest set index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sat_check.sv
// Clause-status evaluator that produces satisfied, conflict and the first conflicting clause.
// Outputs are registered with exactly one cycle of latency, and it updates every cycle with no backpressure.
module sat_check
  import dpll_pkg::*;
#(
  parameter  int MAX_CLAUSES = 16,
  localparam int IDX_W       = $clog2(MAX_CLAUSES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CLAUSE_W*MAX_CLAUSES-1:0] clauses,
  input  logic [MAX_CLAUSES-1:0]          clause_active,
  input  logic [MAX_CLAUSES-1:0]          clause_valid,
  output logic                            return_true,
  output logic                            return_false,
  output logic [IDX_W-1:0]                conflict_idx
);

  logic [CLAUSE_TBL_W-1:0] clause_tbl;
  logic [MAX_CLAUSES-1:0]  live;
  logic [MAX_CLAUSES-1:0]  empty;
  logic [IDX_W-1:0]        enc_idx;
  logic                    enc_found;

  assign clause_tbl = CLAUSE_TBL_W'(clauses);

  // An inactive clause is already satisfied, so a dead mask on it is not a conflict.
  for (genvar i = 0; i < MAX_CLAUSES; i++) begin : g_clause
    assign live[i]  = clause_valid[i] & clause_active[i];
    assign empty[i] = live[i] & clause_dead(clause_slice(clause_tbl, i));
  end

  sat_prio_enc #(
    .N     (MAX_CLAUSES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (empty),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      return_true  <= 1'b0;
      return_false <= 1'b0;
      conflict_idx <= '0;
    end else begin
      return_true  <= ~|live;
      return_false <= enc_found;
      conflict_idx <= enc_idx;
    end
  end

endmodule

// File: tb/tb_sat_check.sv
// Bench for sat_check: directed vectors, reset behaviour and randomized clause tables
// checked against a slot-by-slot reference model.
module tb_sat_check;

  localparam int N = 16;

  logic          clk;
  logic          rst_n;
  logic [3*N-1:0] clauses;
  logic [N-1:0]   clause_active;
  logic [N-1:0]   clause_valid;
  logic           return_true;
  logic           return_false;
  logic [3:0]     conflict_idx;

  int n_chk;
  int n_fail;

  sat_check #(.MAX_CLAUSES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clauses       (clauses),
    .clause_active (clause_active),
    .clause_valid  (clause_valid),
    .return_true   (return_true),
    .return_false  (return_false),
    .conflict_idx  (conflict_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: scan the slots in order and record the first live clause with no surviving literal.
  task automatic model(input logic [3*N-1:0] c, input logic [N-1:0] a, input logic [N-1:0] v,
                       output logic rt, output logic rf, output logic [3:0] ci);
    logic [3*N-1:0] lits;
    rt = 1'b1;
    rf = 1'b0;
    ci = 4'd0;
    for (int i = 0; i < N; i++) begin
      lits = (c >> (3 * i)) & 48'h7;
      if (v[i] && a[i]) begin
        rt = 1'b0;
        if (lits == 0 && !rf) begin
          rf = 1'b1;
          ci = 4'(i);
        end
      end
    end
  endtask

  task automatic drive(input logic [3*N-1:0] c, input logic [N-1:0] a, input logic [N-1:0] v);
    @(negedge clk);
    clauses       = c;
    clause_active = a;
    clause_valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic et, input logic ef, input logic [3:0] ei);
    chk({tag, ".true"},  {31'd0, return_true},  {31'd0, et});
    chk({tag, ".false"}, {31'd0, return_false}, {31'd0, ef});
    chk({tag, ".idx"},   {28'd0, conflict_idx}, {28'd0, ei});
  endtask

  task automatic rand_vec(output logic [3*N-1:0] c, output logic [N-1:0] a, output logic [N-1:0] v);
    c = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) != 0) c[3*i +: 3] = 3'($urandom_range(1, 7));
    end
    a = 16'($urandom);
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       a = '0;
      1:       v = '0;
      2:       a = '1;
      default: ;
    endcase
  endtask

  initial begin
    logic           et, ef;
    logic [3:0]     ei;
    logic [3*N-1:0] rc;
    logic [N-1:0]   ra, rv;

    n_chk  = 0;
    n_fail = 0;

    // Reset with inputs that would otherwise flag a conflict.
    rst_n         = 1'b0;
    clauses       = 48'h000037FAB00D;
    clause_active = 16'h03FD;
    clause_valid  = 16'h03FF;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("post_reset_hold", 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk_out("first_eval", 1'b0, 1'b1, 4'd2);

    drive(48'h000037FAB00D, 16'h03FD, 16'h03FF);
    chk_out("conflict2", 1'b0, 1'b1, 4'd2);
    drive(48'h000037FAB10D, 16'h03FD, 16'h03FF);
    chk_out("conflict3", 1'b0, 1'b1, 4'd3);
    drive(48'h000037FAB50D, 16'h03FD, 16'h03FF);
    chk_out("undecided", 1'b0, 1'b0, 4'd0);
    drive(48'h0, 16'h0000, 16'hFFFF);
    chk_out("all_inactive", 1'b1, 1'b0, 4'd0);
    drive(48'h0, 16'hFFFF, 16'h0000);
    chk_out("all_invalid", 1'b1, 1'b0, 4'd0);
    drive(48'h0, 16'h8000, 16'hFFFF);
    chk_out("conflict15", 1'b0, 1'b1, 4'd15);

    // An asynchronous reset must clear the outputs before the next clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      rand_vec(rc, ra, rv);
      drive(rc, ra, rv);
      model(rc, ra, rv, et, ef, ei);
      chk_out("rand", et, ef, ei);
      chk("rand.exclusive", {31'd0, return_true & return_false}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
